bus1ton: RTL and testbench

//  Registered 1-master-to-N-slave splitter for the valid/ready memory bus.

---
 rtl/bus1ton_pkg.sv | 31 +++
 rtl/bus1ton_if.sv | 41 ++++
 rtl/bus1ton_decode.sv | 32 +++
 rtl/bus1ton.sv | 145 ++++++++++++++
 tb/tb_bus1ton.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus1ton_pkg.sv
// Shared definitions for the bus1ton splitter and related interconnect blocks.
// Provides bus width constants, the FSM state encoding, the request payload
// struct, the default error read-data value and a select-width helper.
package bus1ton_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned MAX_SLAVES = 8;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Latched master request, broadcast to all slaves
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    // Bits needed to index n items; at least one bit so a lone slave still has a select
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus1ton_if.sv
// Valid/ready memory bus bundle around the bus1ton splitter.
// Master side : mvalid, maddr, mwdata, mwstrb -> mready, mrdata, merr
// Slave side  : svalid (one-hot), saddr, swdata, swstrb -> sready, srdata (packed per slave)
// Modports    : slave  - view of the splitter (accepts master requests, drives slaves)
//               master - view of the surrounding environment (core plus slave models)
interface bus1ton_if
    import bus1ton_pkg::*;
#(
    parameter int unsigned N_SLAVES = 2
);

    logic                       mvalid;
    logic                       mready;
    logic [ADDR_W-1:0]          maddr;
    logic [DATA_W-1:0]          mwdata;
    logic [STRB_W-1:0]          mwstrb;
    logic [DATA_W-1:0]          mrdata;
    logic                       merr;

    logic [N_SLAVES-1:0]        svalid;
    logic [N_SLAVES-1:0]        sready;
    logic [ADDR_W-1:0]          saddr;
    logic [DATA_W-1:0]          swdata;
    logic [STRB_W-1:0]          swstrb;
    logic [DATA_W*N_SLAVES-1:0] srdata;

    modport slave (
        input  mvalid, maddr, mwdata, mwstrb,
        output mready, mrdata, merr,
        output svalid, saddr, swdata, swstrb,
        input  sready, srdata
    );

    modport master (
        output mvalid, maddr, mwdata, mwstrb,
        input  mready, mrdata, merr,
        input  svalid, saddr, swdata, swstrb,
        output sready, srdata
    );

endinterface

// File: rtl/bus1ton_decode.sv
// Address window decoder: priority encoder over N base/mask windows.
// Window i hits when (addr & mask_i) == base_i; the lowest hitting index wins.
// Ports:
//   i_addr : address to decode
//   o_hit  : some window matched
//   o_sel  : index of the lowest matching window (0 when no hit)
module bus1ton_decode
    import bus1ton_pkg::*;
#(
    parameter int unsigned                  N_SLAVES = 2,
    parameter logic [ADDR_W*N_SLAVES-1:0]   SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [ADDR_W*N_SLAVES-1:0]   SLV_MASK = {32'hF000_0000, 32'hF000_0000},
    localparam int unsigned                 SEL_W    = sel_width(N_SLAVES)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel
);

    // Scan from the top down so that the last (lowest) match overrides the rest
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((i_addr & SLV_MASK[ADDR_W*i +: ADDR_W]) == SLV_BASE[ADDR_W*i +: ADDR_W]) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus1ton.sv
// Registered 1-master-to-N-slave splitter for the valid/ready memory bus.
// A request seen in IDLE is latched and forwarded to the single decoded slave;
// unmapped addresses complete with merr=1 and ERR_DATA instead of hanging.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : bus1ton_if.slave - master request/response and broadcast slave bus
// The completion response (mready/mrdata/merr) is combinational from the
// registered state so a slave's sready is returned in the same cycle.
// Optional feature: define BUS_TIMEOUT_EN to abort a slave that does not answer
// within TIMEOUT BUSY cycles (error completion); undefined, BUSY waits forever.
module bus1ton
    import bus1ton_pkg::*;
#(
    parameter int unsigned                  N_SLAVES = 2,
    parameter logic [ADDR_W*N_SLAVES-1:0]   SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [ADDR_W*N_SLAVES-1:0]   SLV_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter logic [DATA_W-1:0]            ERR_DATA = ERR_DATA_DEFAULT,
    parameter int unsigned                  TIMEOUT  = 1024
) (
    input  logic      clk,
    input  logic      resetn,
    bus1ton_if.slave  bus
);

    localparam int unsigned SEL_W = sel_width(N_SLAVES);

    // Reject configurations the design is not built for
    if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT < 2) begin : g_bad_cfg
        $error("bus1ton: N_SLAVES must be 1..8 and TIMEOUT >= 2");
    end

    state_e              r_state;
    req_t                r_req;
    logic [SEL_W-1:0]    r_sel;
    logic [N_SLAVES-1:0] r_svalid;

    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic                w_sready_sel;
    logic [DATA_W-1:0]   w_srdata_sel;
    logic                w_done_ok;
    logic                w_done_err;
    logic                w_expire;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = sel_width(TIMEOUT);
    logic [CNT_W-1:0]    r_cnt;
`endif

    // Address decode on the live master address (only consumed in IDLE)
    bus1ton_decode #(
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .i_addr (bus.maddr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    // Selected slave's response and the completion conditions for this cycle
    always_comb begin
        w_sready_sel = bus.sready[r_sel];
        w_srdata_sel = bus.srdata[DATA_W*r_sel +: DATA_W];
        w_done_ok    = (r_state == ST_BUSY) && w_sready_sel;
        w_expire     = 1'b0;
`ifdef BUS_TIMEOUT_EN
        // A same-cycle sready takes priority over expiry
        w_expire     = (r_state == ST_BUSY) && !w_sready_sel
                       && (r_cnt == CNT_W'(TIMEOUT - 1));
`endif
        w_done_err   = (r_state == ST_ERR) || w_expire;
    end

    // Master response; forced to zero outside the completion cycle
    always_comb begin
        bus.mready = w_done_ok || w_done_err;
        bus.merr   = w_done_err;
        bus.mrdata = '0;
        if (w_done_ok) begin
            bus.mrdata = w_srdata_sel;
        end else if (w_done_err) begin
            bus.mrdata = ERR_DATA;
        end
    end

    assign bus.svalid = r_svalid;
    assign bus.saddr  = r_req.addr;
    assign bus.swdata = r_req.wdata;
    assign bus.swstrb = r_req.wstrb;

    // FSM, request registers and slave select
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_req    <= '0;
            r_sel    <= '0;
            r_svalid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mvalid) begin
                        r_req <= '{addr: bus.maddr, wdata: bus.mwdata, wstrb: bus.mwstrb};
                        if (w_hit) begin
                            r_sel    <= w_sel;
                            r_svalid <= N_SLAVES'(1) << w_sel;
                            r_state  <= ST_BUSY;
                        end else begin
                            r_state  <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    // Master inputs are ignored here, even if mvalid drops
                    if (w_done_ok || w_expire) begin
                        r_svalid <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_svalid <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Slave-wait counter: zero on entry to BUSY, counts cycles without sready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state != ST_BUSY) begin
            r_cnt <= '0;
        end else if (!w_sready_sel) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bus1ton.sv
// Self-checking bench for bus1ton: directed scenarios plus randomized traffic
// checked against a transaction-level model of decode, latency and response.
module tb_bus1ton;
    import bus1ton_pkg::*;

    localparam int unsigned NS   = 4;
    localparam int unsigned TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    // Observed (or expected) outcome of one transaction
    typedef struct {
        int          rdy_cyc;
        logic [31:0] rdata;
        logic        err;
        int          sv_first;
        int          sv_cnt;
        logic [NS-1:0] sv_or;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [3:0]  swstrb;
        int          leak;
    } obs_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    bus1ton_if #(.N_SLAVES(NS)) bus();

    // Windows: s0 0xxx, s1 1xxx, s2 2xxx, s3 bit30=0&bit29=1 (overlaps s2 on 2xxx)
    bus1ton #(
        .N_SLAVES (NS),
        .SLV_BASE ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'h6000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .ERR_DATA (ERRD),
        .TIMEOUT  (TMO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int stray = 0;

    // Lowest-numbered window containing the address, or -1
    function automatic int model_target(input logic [31:0] a);
        logic [31:0] base [NS];
        logic [31:0] mask [NS];
        base = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
        mask = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h6000_0000};
        for (int i = 0; i < int'(NS); i++)
            if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    // Expected outcome: cycle 0 is the mvalid cycle, slave sees the request in cycle 1
    function automatic obs_t model_txn(input logic [31:0] a, input logic [31:0] wd,
                                       input logic [3:0] ws, input int wt, input logic [31:0] rd);
        obs_t e;
        int   t;
        int   eff;
        t = model_target(a);
        e = '{rdy_cyc: 1, rdata: ERRD, err: 1'b1, sv_first: -1, sv_cnt: 0, sv_or: '0,
              saddr: '0, swdata: '0, swstrb: '0, leak: 0};
        if (t >= 0) begin
            eff   = wt;
            e.err = 1'b0;
`ifdef BUS_TIMEOUT_EN
            if (wt > int'(TMO) - 1) begin
                eff   = int'(TMO) - 1;
                e.err = 1'b1;
            end
`endif
            e.rdy_cyc  = 1 + eff;
            e.rdata    = e.err ? ERRD : rd;
            e.sv_first = 1;
            e.sv_cnt   = eff + 1;
            e.sv_or    = NS'(1) << t;
            e.saddr    = a;
            e.swdata   = wd;
            e.swstrb   = ws;
        end
        return e;
    endfunction

    // Drive one transaction from a negedge and record what the DUT does.
    // Target slave raises sready in cycle 1+wt; other slaves emit random noise.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int tgt, input int wt, input logic [31:0] rd,
                           input bit drop, input int max_c, output obs_t o);
        logic fin;
        o = '{rdy_cyc: -1, rdata: '0, err: 1'b0, sv_first: -1, sv_cnt: 0, sv_or: '0,
              saddr: '0, swdata: '0, swstrb: '0, leak: 0};
        for (int c = 0; c <= max_c; c++) begin
            if (c == 0) begin
                bus.mvalid = 1'b1; bus.maddr = a; bus.mwdata = wd; bus.mwstrb = ws;
            end else if (drop) begin
                bus.mvalid = 1'b0; bus.maddr = $urandom; bus.mwdata = $urandom;
                bus.mwstrb = 4'($urandom);
            end
            for (int s = 0; s < int'(NS); s++) begin
                if (s == tgt) begin
                    bus.sready[s] = (c == 1 + wt);
                    bus.srdata[32*s +: 32] = rd;
                end else begin
                    bus.sready[s] = 1'($urandom);
                    bus.srdata[32*s +: 32] = $urandom;
                end
            end
            #1;
            fin = bus.mready;
            if (bus.mready === 1'b1) begin
                o.rdy_cyc = c; o.rdata = bus.mrdata; o.err = bus.merr;
            end else if (bus.mrdata !== '0 || bus.merr !== 1'b0) begin
                o.leak++;
            end
            if (bus.svalid !== '0) begin
                if (o.sv_first < 0) begin
                    o.sv_first = c; o.saddr = bus.saddr; o.swdata = bus.swdata;
                    o.swstrb = bus.swstrb;
                end
                o.sv_cnt++;
                o.sv_or |= bus.svalid;
            end
            @(negedge clk);
            if (fin === 1'b1) break;
        end
    endtask

    // Master idle; any mready seen here is a stray completion
    task automatic idle_cycles(input int n);
        bus.mvalid = 1'b0;
        bus.sready = '0;
        repeat (n) begin
            #1;
            if (bus.mready !== 1'b0) stray++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.mvalid = 1'b1; bus.maddr = 32'h1000_0010; bus.mwdata = 32'hFFFF_FFFF;
        bus.mwstrb = 4'hF; bus.sready = '1; bus.srdata = '1;
        repeat (3) begin
            @(negedge clk); #1;
            total++; if (bus.svalid !== '0) begin bad++; $display("FAIL rst_svalid got=%b exp=0", bus.svalid); end
            total++; if (bus.mready !== 1'b0 || bus.merr !== 1'b0 || bus.mrdata !== '0) begin
                bad++; $display("FAIL rst_resp got=%b/%b/%h exp=0/0/0", bus.mready, bus.merr, bus.mrdata); end
            total++; if (bus.saddr !== '0 || bus.swdata !== '0 || bus.swstrb !== '0) begin
                bad++; $display("FAIL rst_sbus got=%h/%h/%h exp=0", bus.saddr, bus.swdata, bus.swstrb); end
        end
        bus.sready = '0;
        resetn = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.svalid !== 4'b0010) begin bad++; $display("FAIL rst_release_svalid got=%b exp=0010", bus.svalid); end
        bus.sready = 4'b0010; bus.srdata[63:32] = 32'h0123_4567;
        #1;
        total++; if (bus.mready !== 1'b1 || bus.mrdata !== 32'h0123_4567) begin
            bad++; $display("FAIL rst_release_resp got=%b/%h exp=1/01234567", bus.mready, bus.mrdata); end
        @(negedge clk);
        idle_cycles(1);
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_txn(32'h1000_0010, 32'h0, 4'h0, 1, 2, 32'hCAFE_0001, 1'b0, 8, o);
        total++; if (o.rdy_cyc !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", o.rdy_cyc); end
        total++; if (o.rdata !== 32'hCAFE_0001 || o.err !== 1'b0) begin
            bad++; $display("FAIL rd_data got=%h/%b exp=cafe0001/0", o.rdata, o.err); end
        total++; if (o.sv_or !== 4'b0010 || o.saddr !== 32'h1000_0010) begin
            bad++; $display("FAIL rd_sbus got=%b/%h exp=0010/10000010", o.sv_or, o.saddr); end
        idle_cycles(1);
    endtask

    task automatic test_write_b2b();
        obs_t o;
        run_txn(32'h0000_0004, 32'h1234_5678, 4'b0011, 0, 0, 32'h0, 1'b0, 6, o);
        total++; if (o.rdy_cyc !== 1) begin bad++; $display("FAIL wr_latency got=%0d exp=1", o.rdy_cyc); end
        total++; if (o.swstrb !== 4'b0011 || o.swdata !== 32'h1234_5678 || o.sv_or !== 4'b0001) begin
            bad++; $display("FAIL wr_sbus got=%b/%h/%b exp=0011/12345678/0001", o.swstrb, o.swdata, o.sv_or); end
        run_txn(32'h1000_0100, 32'h0, 4'h0, 1, 0, 32'h7777_1111, 1'b0, 6, o);
        total++; if (o.sv_first !== 1 || o.rdy_cyc !== 1) begin
            bad++; $display("FAIL b2b_timing got=%0d/%0d exp=1/1", o.sv_first, o.rdy_cyc); end
        total++; if (o.rdata !== 32'h7777_1111 || o.sv_or !== 4'b0010) begin
            bad++; $display("FAIL b2b_data got=%h/%b exp=77771111/0010", o.rdata, o.sv_or); end
        idle_cycles(1);
    endtask

    task automatic test_unmapped();
        obs_t o;
        int   s0;
        run_txn(32'h8000_0000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, 6, o);
        total++; if (o.rdy_cyc !== 1 || o.err !== 1'b1 || o.rdata !== ERRD) begin
            bad++; $display("FAIL unmapped_resp got=%0d/%b/%h exp=1/1/deadbeef", o.rdy_cyc, o.err, o.rdata); end
        total++; if (o.sv_cnt !== 0) begin bad++; $display("FAIL unmapped_svalid got=%0d exp=0", o.sv_cnt); end
        s0 = stray;
        idle_cycles(2);
        total++; if (stray !== s0) begin bad++; $display("FAIL unmapped_pulse got=%0d exp=0", stray - s0); end
    endtask

    task automatic test_timeout();
        obs_t o;
`ifdef BUS_TIMEOUT_EN
        run_txn(32'h0000_0100, 32'h0, 4'h0, 0, 100, 32'h1111_2222, 1'b0, 14, o);
        total++; if (o.rdy_cyc !== 8 || o.err !== 1'b1 || o.rdata !== ERRD) begin
            bad++; $display("FAIL tmo_expire got=%0d/%b/%h exp=8/1/deadbeef", o.rdy_cyc, o.err, o.rdata); end
        total++; if (o.sv_cnt !== 8) begin bad++; $display("FAIL tmo_svalid got=%0d exp=8", o.sv_cnt); end
        idle_cycles(1);
        run_txn(32'h0000_0200, 32'h0, 4'h0, 0, 7, 32'h5A5A_0007, 1'b0, 14, o);
        total++; if (o.rdy_cyc !== 8 || o.err !== 1'b0 || o.rdata !== 32'h5A5A_0007) begin
            bad++; $display("FAIL tmo_race got=%0d/%b/%h exp=8/0/5a5a0007", o.rdy_cyc, o.err, o.rdata); end
`else
        run_txn(32'h0000_0100, 32'h0, 4'h0, 0, 20, 32'h1111_2222, 1'b0, 26, o);
        total++; if (o.rdy_cyc !== 21 || o.err !== 1'b0 || o.rdata !== 32'h1111_2222) begin
            bad++; $display("FAIL long_wait got=%0d/%b/%h exp=21/0/11112222", o.rdy_cyc, o.err, o.rdata); end
        total++; if (o.sv_cnt !== 21) begin bad++; $display("FAIL long_wait_svalid got=%0d exp=21", o.sv_cnt); end
`endif
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bus.mvalid = 1'b1; bus.maddr = 32'h1000_0020; bus.mwdata = 32'hAAAA_5555;
        bus.mwstrb = 4'hF; bus.sready = '0;
        @(negedge clk); #1;
        total++; if (bus.svalid !== 4'b0010) begin bad++; $display("FAIL mid_busy got=%b exp=0010", bus.svalid); end
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        total++; if (bus.svalid !== '0 || bus.mready !== 1'b0 || bus.saddr !== '0) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", bus.svalid, bus.mready, bus.saddr); end
        bus.mvalid = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.mready !== 1'b0) begin bad++; $display("FAIL mid_no_rdy got=%b exp=0", bus.mready); end
        resetn = 1'b1;
        @(negedge clk);
        run_txn(32'h0000_0040, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 6, o);
        total++; if (o.rdy_cyc !== 2 || o.rdata !== 32'h0BAD_F00D || o.err !== 1'b0) begin
            bad++; $display("FAIL mid_recover got=%0d/%h/%b exp=2/0badf00d/0", o.rdy_cyc, o.rdata, o.err); end
        idle_cycles(1);
    endtask

    task automatic test_random();
        obs_t        o;
        obs_t        e;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  ws;
        int          wt;
        bit          drop;
        int          s0;
        s0 = stray;
        for (int i = 0; i < 60; i++) begin
            a    = {4'($urandom_range(0, 15)), 28'($urandom)};
            wd   = $urandom; rd = $urandom; ws = 4'($urandom);
            wt   = $urandom_range(0, 4);
            drop = ($urandom_range(0, 3) == 0);
            e    = model_txn(a, wd, ws, wt, rd);
            run_txn(a, wd, ws, model_target(a), wt, rd, drop, e.rdy_cyc + 3, o);
            total++; if (o.rdy_cyc !== e.rdy_cyc) begin bad++; $display("FAIL rnd%0d_lat a=%h got=%0d exp=%0d", i, a, o.rdy_cyc, e.rdy_cyc); end
            total++; if (o.rdata !== e.rdata || o.err !== e.err) begin
                bad++; $display("FAIL rnd%0d_resp a=%h got=%h/%b exp=%h/%b", i, a, o.rdata, o.err, e.rdata, e.err); end
            total++; if (o.sv_first !== e.sv_first || o.sv_cnt !== e.sv_cnt || o.sv_or !== e.sv_or) begin
                bad++; $display("FAIL rnd%0d_svalid a=%h got=%0d/%0d/%b exp=%0d/%0d/%b", i, a,
                                o.sv_first, o.sv_cnt, o.sv_or, e.sv_first, e.sv_cnt, e.sv_or); end
            total++; if (o.saddr !== e.saddr || o.swdata !== e.swdata || o.swstrb !== e.swstrb) begin
                bad++; $display("FAIL rnd%0d_sbus got=%h/%h/%h exp=%h/%h/%h", i, o.saddr, o.swdata,
                                o.swstrb, e.saddr, e.swdata, e.swstrb); end
            total++; if (o.leak !== 0) begin bad++; $display("FAIL rnd%0d_leak got=%0d exp=0", i, o.leak); end
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
        total++; if (stray !== s0) begin bad++; $display("FAIL rnd_stray got=%0d exp=0", stray - s0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b1;
        bus.mvalid = 1'b0;
        bus.maddr  = '0;
        bus.mwdata = '0;
        bus.mwstrb = '0;
        bus.sready = '0;
        bus.srdata = '0;
        #2;
        test_reset();
        test_read_wait();
        test_write_b2b();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
